// File: rtl/memory_system.sv
// memory_system
//
// Single-port, word-addressed on-chip memory behind a level request / one-cycle
// acknowledge host interface. One transaction (read or write of one word) is
// handled at a time. The array is modelled as a synchronous SRAM: a registered
// read port and a single write port.
//
// Build option:
//   MEM_INIT_EN  defined   -> after every reset the array is filled with
//                              mem[k] = k (one word per cycle) before the host
//                              is served.
//                undefined -> reset goes straight to IDLE and the array contents
//                              are undefined until written.
//
// Ports:
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   host_req    in   1       request level, held until host_ack is seen
//   host_wr_en  in   1       1 = write, 0 = read (valid with host_req)
//   host_addr   in   ADDR_W  byte address; word index = host_addr[log2(DEPTH)+1:2]
//   host_wdata  in   DATA_W  write data (valid with host_req)
//   host_rdata  out  DATA_W  read data / write echo, valid while host_ack = 1,
//                            holds its value between transactions
//   host_ack    out  1       one-cycle completion pulse
//
// Timing: the edge that samples host_req in IDLE is E0; host_ack rises on E3.
//   E0: request captured, enter ACCESS.
//   E1: registered array read (first ACCESS cycle).
//   E2: write commits on the ACCESS exit edge, enter RESP.
//   E3: RESP loads the output registers, host_ack goes high for one cycle.

module memory_system #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StAccess,
        StResp,
        StWaitRel
    } state_e;

`ifdef MEM_INIT_EN
    localparam state_e ResetState = StInit;
`else
    localparam state_e ResetState = StIdle;
`endif

    // FSM and captured request
    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    // ACCESS spans two cycles: 0 = read issue, 1 = read data valid / write commit
    logic                acc_ph_q, acc_ph_d;

    // Output registers
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                host_ack_q, host_ack_d;

`ifdef MEM_INIT_EN
    logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
`endif

    // Array ports
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_re;
    logic [DATA_W-1:0]   mem_rdata_q;

    logic [IDX_W-1:0]    host_idx;

    // Byte offset and bits above the index are ignored: addresses alias modulo DEPTH*4.
    assign host_idx = host_addr[IDX_W+1:2];

    logic unused_addr;
    assign unused_addr = ^{host_addr[ADDR_W-1:IDX_W+2], host_addr[1:0]};

    //------------------------------------------------------------------------
    // Next-state and datapath control
    //------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        acc_ph_d     = acc_ph_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        mem_we       = 1'b0;
        mem_waddr    = idx_q;
        mem_wdata    = wdata_q;
        mem_re       = 1'b0;
`ifdef MEM_INIT_EN
        init_cnt_d   = init_cnt_q;
`endif

        unique case (state_q)
            StInit: begin
`ifdef MEM_INIT_EN
                // host_req is deliberately ignored here; it stays pending for IDLE.
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = DATA_W'(init_cnt_q);
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end

            StIdle: begin
                if (host_req) begin
                    wr_d     = host_wr_en;
                    idx_d    = host_idx;
                    wdata_d  = host_wdata;
                    acc_ph_d = 1'b0;
                    state_d  = StAccess;
                end
            end

            StAccess: begin
                if (!acc_ph_q) begin
                    mem_re   = ~wr_q;
                    acc_ph_d = 1'b1;
                end else begin
                    // Committing on the exit edge means a reset anywhere in
                    // ACCESS drops the write.
                    mem_we  = wr_q;
                    state_d = StResp;
                end
            end

            StResp: begin
                host_ack_d   = 1'b1;
                host_rdata_d = wr_q ? wdata_q : mem_rdata_q;
                state_d      = StWaitRel;
            end

            StWaitRel: begin
                // A request still held after the ack must not start a new transaction.
                if (!host_req) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Control and output registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ResetState;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            acc_ph_q     <= 1'b0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
`ifdef MEM_INIT_EN
            init_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            acc_ph_q     <= acc_ph_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
`ifdef MEM_INIT_EN
            init_cnt_q   <= init_cnt_d;
`endif
        end
    end

    //------------------------------------------------------------------------
    // SRAM array: no reset, registered read port
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rdata_q <= mem[idx_q];
        end
    end

    assign host_rdata = host_rdata_q;
    assign host_ack   = host_ack_q;

endmodule

// File: tb/tb_memory_system.sv
// Self-checking bench for memory_system.
// Expected read data comes from a bench-side word model; each transaction pushes
// its expected value onto a scoreboard queue that is popped when host_ack is seen.

module tb_memory_system;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_req = 1'b0;
    logic              host_wr_en = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    memory_system #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host_req  (host_req),
        .host_wr_en(host_wr_en),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .host_ack  (host_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];
    string             tag_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    bit                check_lat = 1'b0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_fill();
        for (int k = 0; k < int'(DEPTH); k++) model[k] = 32'(k);
    endtask

    function automatic int widx(input logic [ADDR_W-1:0] a);
        return int'(a[11:2]);
    endfunction

    // One host transaction. hold = cycles to keep host_req high after the ack.
    task automatic txn(input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input string tag, input int hold);
        logic [DATA_W-1:0] e;
        string             t;
        int                edges;
        bit                got;
        e = wr ? wd : model[widx(addr)];
        if (wr) model[widx(addr)] = wd;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        host_wr_en = wr;
        host_addr  = addr;
        host_wdata = wd;
        host_req   = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 3000) begin
            @(posedge clk);
            edges++;
            if (edges == 1 && check_lat) begin
                // Request was captured on this edge; later input changes must not matter.
                #1;
                host_wr_en = ~wr;
                host_addr  = ~addr;
                host_wdata = ~wd;
            end
            @(negedge clk);
            if (host_ack === 1'b1) got = 1'b1;
        end
        n_checks++;
        assert (got) else begin
            n_fail++;
            $error("FAIL %s timeout: observed no ack after %0d edges, expected ack", tag, edges);
        end
        if (got) begin
            if (check_lat) check({tag, " latency"}, 32'(edges), 32'd4);
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, host_rdata, e);
        end else begin
            void'(tag_q.pop_front());
            void'(exp_q.pop_front());
        end
        if (hold == 0) host_req = 1'b0;
        @(negedge clk);
        check({tag, " ack width"}, 32'(host_ack), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " held req"}, 32'(host_ack), 32'd0);
        end
        host_req   = 1'b0;
        host_wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_lat = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        host_req = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ack", 32'(host_ack), 32'd0);
        check("reset rdata", host_rdata, 32'd0);
        rst_n     = 1'b1;
        check_lat = 1'b0;
`ifdef MEM_INIT_EN
        model_fill();
`endif
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        model_fill();
        apply_reset();
`ifndef MEM_INIT_EN
        // Without the fill the array is undefined; write the index pattern by hand.
        for (int k = 0; k < 256; k++) txn(1'b1, ADDR_W'(k << 2), 32'(k), "prefill", 0);
`endif

        // 1: init pattern
        for (int i = 0; i < 10; i++) txn(1'b0, ADDR_W'(i << 2), '0, $sformatf("t1_rd%0d", i), 0);

        // 2: write/readback, neighbour untouched before its write
        txn(1'b0, 16'h0190, '0, "t2_neigh", 0);
        for (int i = 0; i < 10; i++)
            txn(1'b1, ADDR_W'((100 + i) << 2), 32'h55AA0000 | 32'(i), $sformatf("t2_wr%0d", i), 0);
        for (int i = 0; i < 10; i++)
            txn(1'b0, ADDR_W'((100 + i) << 2), '0, $sformatf("t2_rd%0d", i), 0);
        txn(1'b0, ADDR_W'(110 << 2), '0, "t2_after", 0);

        // 3: byte offset ignored, upper bits alias
        txn(1'b1, 16'h0003, 32'hDEADBEEF, "t3_wr_off", 0);
        txn(1'b0, 16'h0000, '0, "t3_rd_off", 0);
        txn(1'b1, 16'h1008, 32'h12345678, "t3_wr_alias", 0);
        txn(1'b0, 16'h0008, '0, "t3_rd_alias", 0);

        // 4: request held after ack
        txn(1'b1, 16'h0040, 32'hA5A50F0F, "t4_hold", 5);
        txn(1'b0, 16'h0040, '0, "t4_next", 0);

        // 5: random write/read pairs
        for (int i = 0; i < 20; i++) begin
            a = ADDR_W'($urandom_range(0, 1023));
            d = $urandom;
            txn(1'b1, a, d, $sformatf("t5_wr%0d", i), 0);
            txn(1'b0, a, '0, $sformatf("t5_rd%0d", i), 0);
        end

        // 6: reset during ACCESS of a write to word 110
        host_wr_en = 1'b1;
        host_addr  = ADDR_W'(110 << 2);
        host_wdata = 32'hCAFEF00D;
        host_req   = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6 abort ack", 32'(host_ack), 32'd0);
        check("t6 abort rdata", host_rdata, 32'd0);
        apply_reset();
        @(negedge clk);
        check("t6 post ack", 32'(host_ack), 32'd0);
        check("t6 post rdata", host_rdata, 32'd0);
        txn(1'b0, ADDR_W'(110 << 2), '0, "t6_rd", 0);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
